// File: rtl/bw_io_jtag_pkg.sv
// Shared TAP state encoding, opcodes and data-register select helper for the
// DDR pad-ring boundary-scan controller.
package bw_io_jtag_pkg;

    localparam int IR_W = 4;

    localparam logic [IR_W-1:0] OP_EXTEST = IR_W'(4'h0);
    localparam logic [IR_W-1:0] OP_SAMPLE = IR_W'(4'h1);
    localparam logic [IR_W-1:0] OP_HIGHZ  = IR_W'(4'h2);
    localparam logic [IR_W-1:0] OP_BYPASS = IR_W'(4'hF);

    // Classic 1149.1 reference encoding so a logic analyser trace reads naturally.
    typedef enum logic [3:0] {
        TLR       = 4'hF,
        RTI       = 4'hC,
        SEL_DR    = 4'h7,
        CAP_DR    = 4'h6,
        SHIFT_DR  = 4'h2,
        EXIT1_DR  = 4'h1,
        PAUSE_DR  = 4'h3,
        EXIT2_DR  = 4'h0,
        UPDATE_DR = 4'h5,
        SEL_IR    = 4'h4,
        CAP_IR    = 4'hE,
        SHIFT_IR  = 4'hA,
        EXIT1_IR  = 4'h9,
        PAUSE_IR  = 4'hB,
        EXIT2_IR  = 4'h8,
        UPDATE_IR = 4'hD
    } tap_state_e;

    function automatic logic is_bsr_op(input logic [IR_W-1:0] ir);
        return (ir == OP_EXTEST) || (ir == OP_SAMPLE);
    endfunction

endpackage

// File: rtl/bw_io_tap_fsm.sv
// IEEE 1149.1 16-state TAP controller; exposes current and next state so the
// instruction logic can act on the edge that enters Test-Logic-Reset.
module bw_io_tap_fsm
    import bw_io_jtag_pkg::*;
(
    input  logic       clk,
    input  logic       rst_l,
    input  logic       tms,
    output tap_state_e state,
    output tap_state_e state_nxt
);

    tap_state_e state_q;
    tap_state_e nxt;

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) state_q <= TLR;
        else        state_q <= nxt;
    end

    always_comb begin
        nxt = state_q;
        case (state_q)
            TLR:       nxt = tms ? TLR       : RTI;
            RTI:       nxt = tms ? SEL_DR    : RTI;
            SEL_DR:    nxt = tms ? SEL_IR    : CAP_DR;
            CAP_DR:    nxt = tms ? EXIT1_DR  : SHIFT_DR;
            SHIFT_DR:  nxt = tms ? EXIT1_DR  : SHIFT_DR;
            EXIT1_DR:  nxt = tms ? UPDATE_DR : PAUSE_DR;
            PAUSE_DR:  nxt = tms ? EXIT2_DR  : PAUSE_DR;
            EXIT2_DR:  nxt = tms ? UPDATE_DR : SHIFT_DR;
            UPDATE_DR: nxt = tms ? SEL_DR    : RTI;
            SEL_IR:    nxt = tms ? TLR       : CAP_IR;
            CAP_IR:    nxt = tms ? EXIT1_IR  : SHIFT_IR;
            SHIFT_IR:  nxt = tms ? EXIT1_IR  : SHIFT_IR;
            EXIT1_IR:  nxt = tms ? UPDATE_IR : PAUSE_IR;
            PAUSE_IR:  nxt = tms ? EXIT2_IR  : PAUSE_IR;
            EXIT2_IR:  nxt = tms ? UPDATE_IR : SHIFT_IR;
            UPDATE_IR: nxt = tms ? SEL_DR    : RTI;
            default:   nxt = TLR;
        endcase
    end

    always_comb begin
        state     = state_q;
        state_nxt = nxt;
    end

endmodule

// File: rtl/bw_io_ddr_bscan_ctl.sv
// Boundary-scan TAP and instruction decoder for the DDR pad ring: drives the
// BSR control strobes into every DQ/DQS slice and muxes the chain tail onto tdo.
module bw_io_ddr_bscan_ctl
    import bw_io_jtag_pkg::*;
(
    input  logic clk,
    input  logic rst_l,
    input  logic tms,
    input  logic tdi,
    output logic tdo,
    output logic tdo_en,
    output logic bsi,
    input  logic bso,
    output logic shift_dr,
    output logic clock_dr,
    output logic update_dr,
    output logic mode_ctrl,
    output logic hiz_l
);

    tap_state_e      state;
    tap_state_e      state_nxt;
    logic [IR_W-1:0] ir;
    logic [IR_W-1:0] ir_shift;
    logic            bypass_reg;
    logic            bsr_sel;

    bw_io_tap_fsm u_fsm (
        .clk       (clk),
        .rst_l     (rst_l),
        .tms       (tms),
        .state     (state),
        .state_nxt (state_nxt)
    );

    assign bsr_sel = is_bsr_op(ir);

    // Entering TLR forces BYPASS on the same edge, so pads release immediately.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            ir <= OP_BYPASS;
        end else if (state_nxt == TLR) begin
            ir <= OP_BYPASS;
        end else if (state == UPDATE_IR) begin
            ir <= ir_shift;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            ir_shift <= '0;
        end else if (state == CAP_IR) begin
            ir_shift <= IR_W'(2'b01);
        end else if (state == SHIFT_IR) begin
            ir_shift <= {tdi, ir_shift[IR_W-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            bypass_reg <= 1'b0;
        end else if (state == CAP_DR) begin
            bypass_reg <= 1'b0;
        end else if (state == SHIFT_DR) begin
            bypass_reg <= tdi;
        end
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            tdo    <= 1'b0;
            tdo_en <= 1'b0;
        end else begin
            tdo_en <= (state == SHIFT_IR) || (state == SHIFT_DR);
            if (state == SHIFT_IR)      tdo <= ir_shift[0];
            else if (state == SHIFT_DR) tdo <= bsr_sel ? bso : bypass_reg;
            else                        tdo <= 1'b0;
        end
    end

    // Strobes depend only on registered state and IR, never on the live tms.
    always_comb begin
        clock_dr  = bsr_sel && ((state == CAP_DR) || (state == SHIFT_DR));
        shift_dr  = bsr_sel && (state == SHIFT_DR);
        update_dr = bsr_sel && (state == UPDATE_DR);
        bsi       = bsr_sel && tdi;
        mode_ctrl = (ir == OP_EXTEST) || (ir == OP_HIGHZ);
        hiz_l     = (ir != OP_HIGHZ);
    end

endmodule

// File: tb/tb_bw_io_ddr_bscan_ctl.sv
// Randomized bench for bw_io_ddr_bscan_ctl against a table-driven TAP model,
// plus directed scenarios with literal expectations.
module tb_bw_io_ddr_bscan_ctl;
    import bw_io_jtag_pkg::*;

    logic clk = 1'b0;
    logic rst_l = 1'b1;
    logic tms = 1'b1;
    logic tdi = 1'b0;
    logic bso = 1'b0;
    logic tdo, tdo_en, bsi, shift_dr, clock_dr, update_dr, mode_ctrl, hiz_l;

    bw_io_ddr_bscan_ctl dut (
        .clk       (clk),
        .rst_l     (rst_l),
        .tms       (tms),
        .tdi       (tdi),
        .tdo       (tdo),
        .tdo_en    (tdo_en),
        .bsi       (bsi),
        .bso       (bso),
        .shift_dr  (shift_dr),
        .clock_dr  (clock_dr),
        .update_dr (update_dr),
        .mode_ctrl (mode_ctrl),
        .hiz_l     (hiz_l)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard bookkeeping ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int n_upd = 0;
    int n_sh  = 0;
    int n_clk = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // State numbering is the bench's own; transitions come from the 1149.1 diagram.
    localparam int S_TLR = 0,  S_RTI = 1,  S_SELDR = 2, S_CAPDR = 3;
    localparam int S_SHDR = 4, S_EX1DR = 5, S_PDR = 6, S_EX2DR = 7;
    localparam int S_UPDR = 8, S_SELIR = 9, S_CAPIR = 10, S_SHIR = 11;
    localparam int S_EX1IR = 12, S_PIR = 13, S_EX2IR = 14, S_UPIR = 15;

    int nxt0[16] = '{S_RTI, S_RTI, S_CAPDR, S_SHDR, S_SHDR, S_PDR, S_PDR, S_SHDR,
                     S_RTI, S_CAPIR, S_SHIR, S_SHIR, S_PIR, S_PIR, S_SHIR, S_RTI};
    int nxt1[16] = '{S_TLR, S_SELDR, S_SELIR, S_EX1DR, S_EX1DR, S_UPDR, S_EX2DR, S_UPDR,
                     S_SELDR, S_TLR, S_EX1IR, S_EX1IR, S_UPIR, S_EX2IR, S_UPIR, S_SELDR};

    int         m_st;
    int         m_ns;
    logic [3:0] m_ir;
    logic [3:0] m_irsh;
    logic       m_byp, m_tdo, m_tdo_en, m_bsr;

    assign m_ns  = tms ? nxt1[m_st] : nxt0[m_st];
    assign m_bsr = (m_ir == 4'h0) || (m_ir == 4'h1);

    always @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            m_st     <= S_TLR;
            m_ir     <= 4'hF;
            m_irsh   <= 4'h0;
            m_byp    <= 1'b0;
            m_tdo    <= 1'b0;
            m_tdo_en <= 1'b0;
        end else begin
            m_st     <= m_ns;
            m_tdo_en <= (m_st == S_SHIR) || (m_st == S_SHDR);
            m_tdo    <= (m_st == S_SHIR) ? m_irsh[0] :
                        (m_st == S_SHDR) ? (m_bsr ? bso : m_byp) : 1'b0;
            if (m_st == S_CAPDR)     m_byp <= 1'b0;
            else if (m_st == S_SHDR) m_byp <= tdi;
            if (m_st == S_CAPIR)     m_irsh <= 4'b0001;
            else if (m_st == S_SHIR) m_irsh <= {tdi, m_irsh[3:1]};
            if (m_ns == S_TLR)       m_ir <= 4'hF;
            else if (m_st == S_UPIR) m_ir <= m_irsh;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        check("tdo",       tdo,       m_tdo);
        check("tdo_en",    tdo_en,    m_tdo_en);
        check("bsi",       bsi,       m_bsr & tdi);
        check("clock_dr",  clock_dr,  m_bsr && (m_st == S_CAPDR || m_st == S_SHDR));
        check("shift_dr",  shift_dr,  m_bsr && (m_st == S_SHDR));
        check("update_dr", update_dr, m_bsr && (m_st == S_UPDR));
        check("mode_ctrl", mode_ctrl, (m_ir == 4'h0) || (m_ir == 4'h2));
        check("hiz_l",     hiz_l,     m_ir != 4'h2);
        if (update_dr) n_upd++;
        if (shift_dr)  n_sh++;
        if (clock_dr)  n_clk++;
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic t, input logic d, input logic b);
        tms = t;
        tdi = d;
        bso = b;
        @(posedge clk);
        #2;
    endtask

    task automatic step_rand(input logic t);
        step(t, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic goto_rti();
        repeat (5) step_rand(1'b1);
        step_rand(1'b0);
    endtask

    // From RTI: load an opcode LSB-first and return to RTI.
    task automatic load_ir(input logic [3:0] op, input logic chk);
        step_rand(1'b1);
        step_rand(1'b1);
        step_rand(1'b0);
        step_rand(1'b0);
        if (chk) begin
            exp_q.push_back(8'd1);
            exp_q.push_back(8'd0);
            exp_q.push_back(8'd0);
            exp_q.push_back(8'd0);
        end
        for (int i = 0; i < 4; i++) begin
            step(i == 3, op[i], 1'($urandom_range(0, 1)));
            if (chk && exp_q.size() > 0) check("ir_cap_tdo", tdo, exp_q.pop_front());
        end
        step_rand(1'b1);
        step_rand(1'b0);
    endtask

    // From RTI: capture, shift n bits, update, back to RTI.
    task automatic shift_dr_seq(input int n, input logic [7:0] din, input logic [7:0] bpat,
                                input logic chk);
        step_rand(1'b1);
        step_rand(1'b0);
        step_rand(1'b0);
        for (int i = 0; i < n; i++) begin
            step(i == n - 1, din[i], bpat[i]);
            if (chk && exp_q.size() > 0) check("dr_tdo", tdo, exp_q.pop_front());
        end
        step_rand(1'b1);
        step_rand(1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int up0, sh0, ck0;
        logic [7:0] pat;
        logic [3:0] ops[5];
        ops[0] = 4'h0; ops[1] = 4'h1; ops[2] = 4'h2; ops[3] = 4'hF; ops[4] = 4'h0;

        // 1: reset values
        #1 rst_l = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_ir",        dut.ir,    8'hF);
        check("rst_mode_ctrl", mode_ctrl, 8'd0);
        check("rst_hiz_l",     hiz_l,     8'd1);
        check("rst_strobes",   {shift_dr, clock_dr, update_dr}, 8'd0);
        check("rst_tdo",       {tdo, tdo_en}, 8'd0);
        rst_l = 1'b1;
        step_rand(1'b0);

        // 3: EXTEST shift of 8'hA5 with a known bso stream
        load_ir(4'h0, 1'b1);
        check("extest_mode", mode_ctrl, 8'd1);
        check("extest_hiz",  hiz_l,     8'd1);
        pat = 8'h3C;
        for (int i = 0; i < 8; i++) exp_q.push_back({7'd0, pat[i]});
        up0 = n_upd; sh0 = n_sh; ck0 = n_clk;
        shift_dr_seq(8, 8'hA5, pat, 1'b1);
        check("extest_shift_cnt",  8'(n_sh - sh0),  8'd8);
        check("extest_clock_cnt",  8'(n_clk - ck0), 8'd9);
        check("extest_update_cnt", 8'(n_upd - up0), 8'd1);

        // 2: from Shift-DR, five tms=1 edges reach TLR
        step_rand(1'b1);
        step_rand(1'b0);
        step_rand(1'b0);
        repeat (4) step_rand(1'b1);
        check("tlr_before_5th_mode", mode_ctrl, 8'd1);
        step_rand(1'b1);
        check("tlr_ir",    dut.ir, 8'hF);
        check("tlr_state", dut.u_fsm.state, TLR);
        check("tlr_mode",  mode_ctrl, 8'd0);
        step_rand(1'b0);

        // 4: HIGHZ selects bypass
        load_ir(4'h2, 1'b0);
        check("highz_hiz",  hiz_l,     8'd0);
        check("highz_mode", mode_ctrl, 8'd1);
        exp_q.push_back(8'd0); exp_q.push_back(8'd1);
        exp_q.push_back(8'd0); exp_q.push_back(8'd1);
        sh0 = n_sh; ck0 = n_clk;
        shift_dr_seq(4, 8'b0000_1101, 8'($urandom), 1'b1);
        check("highz_shift_cnt", 8'(n_sh - sh0),  8'd0);
        check("highz_clock_cnt", 8'(n_clk - ck0), 8'd0);

        // 5: capture pattern and undefined opcode behaves as BYPASS
        load_ir(4'h7, 1'b1);
        check("op7_mode", mode_ctrl, 8'd0);
        check("op7_hiz",  hiz_l,     8'd1);
        exp_q.push_back(8'd0); exp_q.push_back(8'd1); exp_q.push_back(8'd1);
        sh0 = n_sh;
        shift_dr_seq(3, 8'b0000_0011, 8'($urandom), 1'b1);
        check("op7_shift_cnt", 8'(n_sh - sh0), 8'd0);

        // 6: reset in the middle of an EXTEST Shift-DR
        load_ir(4'h0, 1'b0);
        step_rand(1'b1);
        step_rand(1'b0);
        step_rand(1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        up0 = n_upd;
        #1 rst_l = 1'b0;
        #1;
        check("midrst_mode",    mode_ctrl, 8'd0);
        check("midrst_strobes", {shift_dr, clock_dr, update_dr}, 8'd0);
        check("midrst_ir",      dut.ir, 8'hF);
        check("midrst_tdo",     {tdo, tdo_en}, 8'd0);
        step_rand(1'b0);
        step_rand(1'b1);
        rst_l = 1'b1;
        repeat (3) step_rand(1'b1);
        check("midrst_no_update", 8'(n_upd - up0), 8'd0);
        check("midrst_mode_after", mode_ctrl, 8'd0);
        step_rand(1'b0);

        // randomized phase: opcode loads, random shifts, free TAP walks
        for (int it = 0; it < 12; it++) begin
            goto_rti();
            load_ir((it % 3 == 2) ? 4'($urandom) : ops[$urandom_range(0, 4)], 1'b0);
            shift_dr_seq($urandom_range(1, 8), 8'($urandom), 8'($urandom), 1'b0);
            for (int k = 0; k < 150; k++) begin
                step_rand(1'($urandom_range(0, 99) < 40));
                if (it == 6 && k == 77) begin
                    #1 rst_l = 1'b0;
                    step_rand(1'b0);
                    rst_l = 1'b1;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
